load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: aligns, masks and extends byte/half/word accesses between
// the EM pipeline stage and a single-ported data memory with a ready handshake.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  misaligned,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [15:0]           lane;
  logic                  access, illegal, accept, in_req;

  assign access = rd_en | wr_en;
  assign in_req = (state_q == REQ);

  always_comb begin
    illegal = 1'b1;
    case (funct3)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = addr[0];
      3'b010:         illegal = |addr[1:0];
      default:        illegal = 1'b1;
    endcase
  end

  assign accept = (state_q == IDLE) && access && !illegal;

  // Input-driven outputs are gated by reset so they read 0 while reset is held.
  assign misaligned = !reset && (state_q == IDLE) && access && illegal;
  assign stall      = !reset && (accept || in_req);
  assign rdata      = misaligned ? '0 : rdata_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (mem_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lane     = 16'(mem_rdata >> {addr_q[1:0], 3'b000});
    load_ext = mem_rdata;
    case (funct3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (in_req) begin
      mem_req  = 1'b1;
      mem_we   = we_q;
      mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      case (funct3_q[1:0])
        2'b00: begin
          mem_be    = 4'b0001 << addr_q[1:0];
          mem_wdata = {(DATA_WIDTH/8){wdata_q[7:0]}};
        end
        2'b01: begin
          mem_be    = 4'b0011 << {addr_q[1], 1'b0};
          mem_wdata = {(DATA_WIDTH/16){wdata_q[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = wdata_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= addr;
        funct3_q <= funct3;
        wdata_q  <= wdata;
        we_q     <= wr_en;
      end
      if (in_req && mem_ready && !we_q)
        rdata_q <= load_ext;
    end
  end

endmodule
